// File: rtl/fp_f2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_f2_pkg
// Description : Shared FP-F2 datapath constants for destination-index blocks.
//               Register width, index width, bank depth and the hard-wired
//               zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_f2_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-destination scoreboard. One bit per register, set on
//               issue and cleared on write-back. It produces per-operand
//               pending flags and the combined stall.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard #(
    parameter bit BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_en,
    input  logic [fp_f2_pkg::ADDR_W-1:0] iss_addr,
    input  logic                         wr_en,
    input  logic [fp_f2_pkg::ADDR_W-1:0] wr_addr,
    input  logic [fp_f2_pkg::ADDR_W-1:0] rd_addr1,
    input  logic [fp_f2_pkg::ADDR_W-1:0] rd_addr2,
    output logic                         pend1,
    output logic                         pend2,
    output logic                         stall
);
    import fp_f2_pkg::*;

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_pending_nxt;
    logic             w_hit1;
    logic             w_hit2;

    // Next pending vector: the clear is applied first so a same-cycle issue
    // to the same index leaves the bit set (a newer producer is in flight).
    always_comb begin
        w_pending_nxt = r_pending;
        if (wr_en) begin
            w_pending_nxt[wr_addr] = 1'b0;
        end
        if (iss_en && (iss_addr != REG_ZERO)) begin
            w_pending_nxt[iss_addr] = 1'b1;
        end
    end

    // Pending state; reset wipes any in-flight issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // A write-back arriving this cycle only resolves the hazard when it can be
    // forwarded; without forwarding the consumer must wait one more cycle.
    always_comb begin
        w_hit1 = BYPASS && wr_en && (wr_addr == rd_addr1);
        w_hit2 = BYPASS && wr_en && (wr_addr == rd_addr2);
        pend1  = r_pending[rd_addr1] && !w_hit1;
        pend2  = r_pending[rd_addr2] && !w_hit2;
        stall  = pend1 || pend2;
    end

endmodule
`default_nettype wire

// File: rtl/dest_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : dest_reg_writeback
// Description : Write-back end of the FP-F2 destination-register path.
//               Register bank with hard-wired zero register, two
//               combinational read ports with optional write-to-read
//               forwarding, and a pending scoreboard that raises stall.
// Revision    : 1.0 - initial release
// ============================================================================
module dest_reg_writeback #(
    parameter bit BYPASS = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         iss_en,
    input  logic [fp_f2_pkg::ADDR_W-1:0] iss_addr,
    input  logic                         wr_en,
    input  logic [fp_f2_pkg::ADDR_W-1:0] wr_addr,
    input  logic [fp_f2_pkg::DATA_W-1:0] wr_data,
    input  logic [fp_f2_pkg::ADDR_W-1:0] rd_addr1,
    input  logic [fp_f2_pkg::ADDR_W-1:0] rd_addr2,
    output logic [fp_f2_pkg::DATA_W-1:0] rd_data1,
    output logic [fp_f2_pkg::DATA_W-1:0] rd_data2,
    output logic                         pend1,
    output logic                         pend2,
    output logic                         stall
);
    import fp_f2_pkg::*;

    // Widths come from the shared package so every FP-F2 block agrees on them.
    reg_data_t r_regs [NREGS];

    // Register bank; index 0 is never written so it stays at its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != REG_ZERO)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Read ports: zero register first, then forwarded write data, then array.
    always_comb begin
        rd_data1 = r_regs[rd_addr1];
        rd_data2 = r_regs[rd_addr2];
        if (rd_addr1 == REG_ZERO) begin
            rd_data1 = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
        if (rd_addr2 == REG_ZERO) begin
            rd_data2 = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
    end

    rf_scoreboard #(
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .pend1    (pend1),
        .pend2    (pend2),
        .stall    (stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_dest_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_dest_reg_writeback
// Description : Scoreboard bench for dest_reg_writeback. Two instances
//               (forwarding on and off) share stimulus; a reference model
//               pushes expected outputs into a queue that a monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dest_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;

    logic [31:0] b1_rd1, b1_rd2, b0_rd1, b0_rd2;
    logic        b1_p1, b1_p2, b1_st, b0_p1, b0_p2, b0_st;

    always #5 clk = ~clk;

    dest_reg_writeback #(.BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst(rst), .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b1_rd1), .rd_data2(b1_rd2),
        .pend1(b1_p1), .pend2(b1_p2), .stall(b1_st)
    );

    dest_reg_writeback #(.BYPASS(1'b0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .iss_en(iss_en), .iss_addr(iss_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b0_rd1), .rd_data2(b0_rd2),
        .pend1(b0_p1), .pend2(b0_p2), .stall(b0_st)
    );

    typedef struct {
        logic [31:0] rd1 [2];
        logic [31:0] rd2 [2];
        logic        p1  [2];
        logic        p2  [2];
        logic        st  [2];
    } exp_t;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          stim_done = 0;

    // Reference model: architectural register values and the set of
    // destinations that have been issued but not yet written back.
    logic [31:0] m_regs [32];
    bit          m_pend [32];

    function automatic logic [31:0] m_read(int byp, logic [4:0] a);
        if (a == 0) return 32'd0;
        if (byp != 0 && wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic m_pending(int byp, logic [4:0] a);
        if (byp != 0 && wr_en && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus: drive, record the expected response, advance model.
    task automatic step(bit push, bit r, bit ie, logic [4:0] ia, bit we,
                        logic [4:0] wa, logic [31:0] wd,
                        logic [4:0] a1, logic [4:0] a2);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; iss_en = ie; iss_addr = ia; wr_en = we; wr_addr = wa;
        wr_data = wd; rd_addr1 = a1; rd_addr2 = a2;
        for (int b = 0; b < 2; b++) begin
            e.rd1[b] = m_read(b, a1);
            e.rd2[b] = m_read(b, a2);
            e.p1[b]  = m_pending(b, a1);
            e.p2[b]  = m_pending(b, a2);
            e.st[b]  = e.p1[b] | e.p2[b];
        end
        if (push) exp_q.push_back(e);
        if (r) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = 32'd0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we && wa != 0) m_regs[wa] = wd;
            if (we) m_pend[wa] = 1'b0;
            if (ie && ia != 0) m_pend[ia] = 1'b1;
        end
    endtask

    // Monitor: outputs are always presented, so compare each cycle that has
    // an outstanding expectation, away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("byp rd_data1", b1_rd1, e.rd1[1]);
            chk("byp rd_data2", b1_rd2, e.rd2[1]);
            chk("byp pend1", {31'd0, b1_p1}, {31'd0, e.p1[1]});
            chk("byp pend2", {31'd0, b1_p2}, {31'd0, e.p2[1]});
            chk("byp stall", {31'd0, b1_st}, {31'd0, e.st[1]});
            chk("nobyp rd_data1", b0_rd1, e.rd1[0]);
            chk("nobyp rd_data2", b0_rd2, e.rd2[0]);
            chk("nobyp pend1", {31'd0, b0_p1}, {31'd0, e.p1[0]});
            chk("nobyp pend2", {31'd0, b0_p2}, {31'd0, e.p2[0]});
            chk("nobyp stall", {31'd0, b0_st}, {31'd0, e.st[0]});
        end
    end

    initial begin
        rst = 1'b1; iss_en = 0; iss_addr = 0; wr_en = 0; wr_addr = 0;
        wr_data = 0; rd_addr1 = 0; rd_addr2 = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        // Initial reset: DUT state is unknown before this edge, so no check.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Reset clears a written register and leaves no stall.
        step(1, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 5, 0);
        step(1, 0, 0, 0, 0, 0, 0, 5, 0);
        // Write then read one cycle later.
        step(1, 0, 0, 0, 1, 7, 32'h0000_1234, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 7);
        // Zero register ignores writes and issues.
        step(1, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        step(1, 0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Hazard on r9, resolved by a same-cycle write-back, then settled.
        step(1, 0, 1, 9, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 9, 0);
        step(1, 0, 0, 0, 1, 9, 32'h0000_00A5, 9, 9);
        step(1, 0, 0, 0, 0, 0, 0, 9, 9);
        // Same-cycle issue and write-back: bit stays set until a second write.
        step(1, 0, 1, 3, 1, 3, 32'h3333_0001, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 3, 0);
        step(1, 0, 0, 0, 1, 3, 32'h3333_0002, 0, 3);
        step(1, 0, 0, 0, 0, 0, 0, 3, 3);
        // Re-issue to a pending index and write-back to a non-pending index.
        step(1, 0, 1, 10, 1, 11, 32'h1111_0011, 0, 0);
        step(1, 0, 1, 10, 0, 0, 0, 10, 11);
        step(1, 0, 0, 0, 1, 10, 32'h1010_1010, 10, 11);
        // Reset mid-flight discards outstanding issues.
        step(1, 0, 1, 4, 1, 4, 32'h4444_4444, 0, 0);
        step(1, 0, 1, 6, 0, 0, 0, 4, 6);
        step(1, 1, 1, 8, 1, 12, 32'hCCCC_CCCC, 4, 6);
        step(1, 0, 0, 0, 0, 0, 0, 4, 6);
        step(1, 0, 0, 0, 0, 0, 0, 8, 12);

        // Randomized traffic over a narrow index range to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            step(1, ($urandom_range(0, 49) == 0),
                 $urandom_range(0, 1), 5'($urandom_range(0, 7)),
                 $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        stim_done = 1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        int budget;
        budget = 0;
        wait (stim_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
